// File: rtl/spin_ctrl_if.sv
// Status/handshake bundle between the spin controller and the guess evaluator.
// Member names keep the controller-side direction suffixes so they read the
// same at the controller's port and at the evaluator.
interface spin_ctrl_if;
    logic       start_i;
    logic [2:0] pos_o;
    logic       running_o;
    logic       done_o;

    // Spin controller side
    modport slave  (input start_i, output pos_o, output running_o, output done_o);
    // Requester / evaluator side
    modport master (output start_i, input pos_o, input running_o, input done_o);
endinterface

// File: rtl/spin_ctrl.sv
// Spinning-LED controller: on a rising start edge it walks pos 0..5 with a
// step period that grows each step up to a cap. It stops after a pseudo-random
// number of steps and holds the final position with running low.
module spin_ctrl #(
    parameter int TICK_DIV     = 1000,
    parameter int START_PERIOD = 2,
    parameter int MAX_PERIOD   = 16,
    parameter int MIN_STEPS    = 12
) (
    input  logic        clk_i,
    input  logic        reset_i,
    spin_ctrl_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SPIN, STOPPED} state_t;

    state_t        state_q;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          start_q;
    logic [TW-1:0] tick_cnt_q;
    logic [4:0]    per_cnt_q, period_q, steps_left_q;
    logic [2:0]    pos_q, pos_d;
    logic          running_q, done_q;

    logic start_rise, tick, step;

    assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign start_rise = bus.start_i & ~start_q;
    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign step       = tick && (per_cnt_q == period_q - 5'd1);
    assign pos_d      = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;

    // Spin FSM plus free-running LFSR and start edge detector; all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            lfsr_q       <= 8'hA5;
            start_q      <= 1'b0;
            tick_cnt_q   <= '0;
            per_cnt_q    <= '0;
            period_q     <= '0;
            steps_left_q <= '0;
            pos_q        <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= bus.start_i;
            done_q  <= 1'b0;
            case (state_q)
                IDLE, STOPPED: begin
                    // Resume from the held position; step count uses the pre-update LFSR.
                    if (start_rise) begin
                        state_q      <= SPIN;
                        running_q    <= 1'b1;
                        steps_left_q <= 5'(MIN_STEPS) + {1'b0, lfsr_q[3:0]};
                        period_q     <= 5'(START_PERIOD);
                        tick_cnt_q   <= '0;
                        per_cnt_q    <= '0;
                    end
                end
                SPIN: begin
                    tick_cnt_q <= tick ? '0 : TW'(tick_cnt_q + 1'b1);
                    if (tick) begin
                        if (step) begin
                            per_cnt_q    <= '0;
                            pos_q        <= pos_d;
                            steps_left_q <= steps_left_q - 5'd1;
                            if (period_q < 5'(MAX_PERIOD))
                                period_q <= period_q + 5'd1;
                            // Last step: final position and stop status land together.
                            if (steps_left_q == 5'd1) begin
                                state_q   <= STOPPED;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            per_cnt_q <= per_cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pos_o     = pos_q;
    assign bus.running_o = running_q;
    assign bus.done_o    = done_q;
endmodule
